// File: rtl/ssd1306_pkg.sv
// rtl/ssd1306_pkg.sv - shared types and SSD1306 opcode constants for the OLED SPI sink
package ssd1306_pkg;

    typedef enum logic [1:0] {
        MODE_HORIZ = 2'd0,
        MODE_VERT  = 2'd1,
        MODE_PAGE  = 2'd2
    } addr_mode_t;

    typedef enum logic [1:0] {
        CMD_IDLE = 2'd0,
        CMD_ARG1 = 2'd1,
        CMD_ARG2 = 2'd2,
        CMD_SKIP = 2'd3
    } cmd_state_t;

    localparam logic [7:0] CMD_SET_MODE    = 8'h20;
    localparam logic [7:0] CMD_COL_ADDR    = 8'h21;
    localparam logic [7:0] CMD_PAGE_ADDR   = 8'h22;
    localparam logic [7:0] CMD_CONTRAST    = 8'h81;
    localparam logic [7:0] CMD_DISP_OFF    = 8'hAE;
    localparam logic [7:0] CMD_DISP_ON     = 8'hAF;
    localparam logic [7:0] CMD_NORMAL      = 8'hA6;
    localparam logic [7:0] CMD_INVERT      = 8'hA7;
    localparam logic [7:0] CMD_SEG_NORM    = 8'hA0;
    localparam logic [7:0] CMD_SEG_REMAP   = 8'hA1;
    localparam logic [7:0] CMD_COM_NORM    = 8'hC0;
    localparam logic [7:0] CMD_COM_FLIP    = 8'hC8;
    localparam logic [7:0] CMD_MUX_RATIO   = 8'hA8;
    localparam logic [7:0] CMD_DISP_OFFSET = 8'hD3;
    localparam logic [7:0] CMD_CLK_DIV     = 8'hD5;
    localparam logic [7:0] CMD_PRECHARGE   = 8'hD9;
    localparam logic [7:0] CMD_COM_PINS    = 8'hDA;
    localparam logic [7:0] CMD_VCOMH       = 8'hDB;
    localparam logic [7:0] CMD_CHARGE_PUMP = 8'h8D;

    localparam logic [7:0] CONTRAST_RESET  = 8'h7F;

    // Opcodes whose single argument byte is consumed and discarded.
    function automatic logic is_skip_op(input logic [7:0] op);
        return (op == CMD_MUX_RATIO)  || (op == CMD_DISP_OFFSET) ||
               (op == CMD_CLK_DIV)    || (op == CMD_PRECHARGE)   ||
               (op == CMD_COM_PINS)   || (op == CMD_VCOMH)       ||
               (op == CMD_CHARGE_PUMP);
    endfunction

    // Opcodes that need at least one argument byte handled by ARG1.
    function automatic logic is_arg_op(input logic [7:0] op);
        return (op == CMD_SET_MODE) || (op == CMD_COL_ADDR) ||
               (op == CMD_PAGE_ADDR) || (op == CMD_CONTRAST);
    endfunction

endpackage

// File: rtl/ssd1306_spi_rx.sv
// rtl/ssd1306_spi_rx.sv - SPI mode-0 MSB-first deserialiser producing one byte strobe per 8 rising edges
module ssd1306_spi_rx (
    input  logic       clk_avr_16,
    input  logic       reset_n,
    input  logic       oled_rst,
    input  logic       oled_cs,
    input  logic       oled_dc,
    input  logic       oled_clk,
    input  logic       oled_data,
    output logic       byte_vld,
    output logic [7:0] rx_byte,
    output logic       rx_dc
);

    logic       sck_q;
    logic [6:0] shift_q;
    logic [2:0] bit_cnt;
    logic       sck_rise;

    // SCK is produced in this clock domain, so a single register suffices for edge detection.
    assign sck_rise = oled_clk & ~sck_q & ~oled_cs;

    // Shift in one bit per SCK rise; the eighth rise emits the byte together with the DC level at that rise.
    always_ff @(posedge clk_avr_16 or negedge reset_n) begin
        if (!reset_n) begin
            sck_q    <= 1'b0;
            shift_q  <= '0;
            bit_cnt  <= '0;
            byte_vld <= 1'b0;
            rx_byte  <= '0;
            rx_dc    <= 1'b0;
        end else if (!oled_rst) begin
            sck_q    <= oled_clk;
            shift_q  <= '0;
            bit_cnt  <= '0;
            byte_vld <= 1'b0;
            rx_byte  <= '0;
            rx_dc    <= 1'b0;
        end else begin
            sck_q    <= oled_clk;
            byte_vld <= 1'b0;
            if (oled_cs) begin
                bit_cnt <= '0;
            end else if (sck_rise) begin
                shift_q <= {shift_q[5:0], oled_data};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_vld <= 1'b1;
                    rx_byte  <= {shift_q, oled_data};
                    rx_dc    <= oled_dc;
                end
            end
        end
    end

endmodule

// File: rtl/ssd1306_spi_sink.sv
// rtl/ssd1306_spi_sink.sv - SSD1306 command decoder and framebuffer writer (optional SSD1306_FRAME_STROBE_EN adds frame_done)
module ssd1306_spi_sink
    import ssd1306_pkg::*;
#(
    parameter int NUM_COLS      = 128,
    parameter int NUM_PAGES     = 8,
    parameter int FB_ADDR_WIDTH = 10
) (
    input  logic                     clk_avr_16,
    input  logic                     reset_n,
    input  logic                     oled_cs,
    input  logic                     oled_rst,
    input  logic                     oled_dc,
    input  logic                     oled_clk,
    input  logic                     oled_data,
    output logic                     fb_wr_en,
    output logic [FB_ADDR_WIDTH-1:0] fb_wr_addr,
    output logic [7:0]               fb_wr_data,
    output logic                     display_on,
    output logic [7:0]               contrast,
    output logic                     invert,
    output logic                     seg_remap,
    output logic                     com_flip
`ifdef SSD1306_FRAME_STROBE_EN
    ,
    output logic                     frame_done
`endif
);

    localparam int COL_W  = $clog2(NUM_COLS);
    localparam int PAGE_W = $clog2(NUM_PAGES);

    logic             byte_vld;
    logic [7:0]       rx_byte;
    logic             rx_dc;

    cmd_state_t       state_q, state_d;
    logic [7:0]       cmd_q;
    addr_mode_t       mode_q;
    logic [COL_W-1:0] col_q, col_start_q, col_end_q, col_nx;
    logic [PAGE_W-1:0] page_q, page_start_q, page_end_q, page_nx;
    logic [COL_W:0]   col_inc;
    logic [PAGE_W:0]  page_inc;
    logic             col_wrap, page_wrap;
    logic [FB_ADDR_WIDTH-1:0] addr_cur;

    ssd1306_spi_rx u_rx (
        .clk_avr_16 (clk_avr_16),
        .reset_n    (reset_n),
        .oled_rst   (oled_rst),
        .oled_cs    (oled_cs),
        .oled_dc    (oled_dc),
        .oled_clk   (oled_clk),
        .oled_data  (oled_data),
        .byte_vld   (byte_vld),
        .rx_byte    (rx_byte),
        .rx_dc      (rx_dc)
    );

    // Increments are one bit wider so a pointer at the top of the range still compares past the window end.
    assign col_inc   = {1'b0, col_q} + 1'b1;
    assign page_inc  = {1'b0, page_q} + 1'b1;
    assign col_wrap  = col_inc > {1'b0, col_end_q};
    assign page_wrap = page_inc > {1'b0, page_end_q};
    assign addr_cur  = FB_ADDR_WIDTH'(page_q) * FB_ADDR_WIDTH'(NUM_COLS) + FB_ADDR_WIDTH'(col_q);

    // Pointer position after a data byte, according to the addressing mode.
    always_comb begin
        col_nx  = col_q;
        page_nx = page_q;
        case (mode_q)
            MODE_HORIZ: begin
                if (col_wrap) begin
                    col_nx  = col_start_q;
                    page_nx = page_wrap ? page_start_q : page_inc[PAGE_W-1:0];
                end else begin
                    col_nx = col_inc[COL_W-1:0];
                end
            end
            MODE_VERT: begin
                if (page_wrap) begin
                    page_nx = page_start_q;
                    col_nx  = col_wrap ? col_start_q : col_inc[COL_W-1:0];
                end else begin
                    page_nx = page_inc[PAGE_W-1:0];
                end
            end
            default: begin
                col_nx = (col_q == COL_W'(NUM_COLS - 1)) ? '0 : col_inc[COL_W-1:0];
            end
        endcase
    end

    // Command FSM next state: only command bytes move it; data bytes leave pending arguments pending.
    always_comb begin
        state_d = state_q;
        if (byte_vld && !rx_dc) begin
            case (state_q)
                CMD_IDLE: begin
                    if (is_arg_op(rx_byte))       state_d = CMD_ARG1;
                    else if (is_skip_op(rx_byte)) state_d = CMD_SKIP;
                end
                CMD_ARG1: begin
                    state_d = ((cmd_q == CMD_COL_ADDR) || (cmd_q == CMD_PAGE_ADDR)) ? CMD_ARG2 : CMD_IDLE;
                end
                default: state_d = CMD_IDLE;
            endcase
        end
    end

    // Command FSM state register.
    always_ff @(posedge clk_avr_16 or negedge reset_n) begin
        if (!reset_n)       state_q <= CMD_IDLE;
        else if (!oled_rst) state_q <= CMD_IDLE;
        else                state_q <= state_d;
    end

    // Framebuffer write port, pointer/window registers and display control state.
    always_ff @(posedge clk_avr_16 or negedge reset_n) begin
        if (!reset_n) begin
            fb_wr_en     <= 1'b0;
            fb_wr_addr   <= '0;
            fb_wr_data   <= '0;
            display_on   <= 1'b0;
            contrast     <= CONTRAST_RESET;
            invert       <= 1'b0;
            seg_remap    <= 1'b0;
            com_flip     <= 1'b0;
            cmd_q        <= '0;
            mode_q       <= MODE_PAGE;
            col_q        <= '0;
            page_q       <= '0;
            col_start_q  <= '0;
            col_end_q    <= COL_W'(NUM_COLS - 1);
            page_start_q <= '0;
            page_end_q   <= PAGE_W'(NUM_PAGES - 1);
        end else if (!oled_rst) begin
            fb_wr_en     <= 1'b0;
            fb_wr_addr   <= '0;
            fb_wr_data   <= '0;
            display_on   <= 1'b0;
            contrast     <= CONTRAST_RESET;
            invert       <= 1'b0;
            seg_remap    <= 1'b0;
            com_flip     <= 1'b0;
            cmd_q        <= '0;
            mode_q       <= MODE_PAGE;
            col_q        <= '0;
            page_q       <= '0;
            col_start_q  <= '0;
            col_end_q    <= COL_W'(NUM_COLS - 1);
            page_start_q <= '0;
            page_end_q   <= PAGE_W'(NUM_PAGES - 1);
        end else begin
            fb_wr_en <= 1'b0;
            if (byte_vld && rx_dc) begin
                fb_wr_en   <= 1'b1;
                fb_wr_addr <= addr_cur;
                fb_wr_data <= rx_byte;
                col_q      <= col_nx;
                page_q     <= page_nx;
            end else if (byte_vld) begin
                case (state_q)
                    CMD_IDLE: begin
                        cmd_q <= rx_byte;
                        if (rx_byte[7:4] == 4'h0)      col_q[3:0] <= rx_byte[3:0];
                        else if (rx_byte[7:4] == 4'h1) col_q[COL_W-1:4] <= rx_byte[COL_W-5:0];
                        else if (rx_byte[7:3] == 5'b10110) page_q <= rx_byte[PAGE_W-1:0];
                        else begin
                            case (rx_byte)
                                CMD_DISP_OFF:  display_on <= 1'b0;
                                CMD_DISP_ON:   display_on <= 1'b1;
                                CMD_NORMAL:    invert     <= 1'b0;
                                CMD_INVERT:    invert     <= 1'b1;
                                CMD_SEG_NORM:  seg_remap  <= 1'b0;
                                CMD_SEG_REMAP: seg_remap  <= 1'b1;
                                CMD_COM_NORM:  com_flip   <= 1'b0;
                                CMD_COM_FLIP:  com_flip   <= 1'b1;
                                default: ;
                            endcase
                        end
                    end
                    CMD_ARG1: begin
                        case (cmd_q)
                            CMD_SET_MODE: if (rx_byte[1:0] != 2'd3) mode_q <= addr_mode_t'(rx_byte[1:0]);
                            CMD_CONTRAST: contrast <= rx_byte;
                            CMD_COL_ADDR: begin
                                col_start_q <= rx_byte[COL_W-1:0];
                                col_q       <= rx_byte[COL_W-1:0];
                            end
                            CMD_PAGE_ADDR: begin
                                page_start_q <= rx_byte[PAGE_W-1:0];
                                page_q       <= rx_byte[PAGE_W-1:0];
                            end
                            default: ;
                        endcase
                    end
                    CMD_ARG2: begin
                        if (cmd_q == CMD_COL_ADDR)  col_end_q  <= rx_byte[COL_W-1:0];
                        if (cmd_q == CMD_PAGE_ADDR) page_end_q <= rx_byte[PAGE_W-1:0];
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef SSD1306_FRAME_STROBE_EN
    // Frame strobe accompanies the write whose advance returns the pointer to the window origin.
    always_ff @(posedge clk_avr_16 or negedge reset_n) begin
        if (!reset_n)       frame_done <= 1'b0;
        else if (!oled_rst) frame_done <= 1'b0;
        else                frame_done <= byte_vld && rx_dc && (mode_q != MODE_PAGE) && col_wrap && page_wrap;
    end
`endif

endmodule

// File: tb/tb_ssd1306_spi_sink.sv
// tb/tb_ssd1306_spi_sink.sv - scoreboard bench for ssd1306_spi_sink against a byte-level reference model
module tb_ssd1306_spi_sink;

    logic       clk_avr_16 = 1'b0;
    logic       reset_n, oled_cs, oled_rst, oled_dc, oled_clk, oled_data;
    logic       fb_wr_en;
    logic [9:0] fb_wr_addr;
    logic [7:0] fb_wr_data;
    logic       display_on, invert, seg_remap, com_flip;
    logic [7:0] contrast;
`ifdef SSD1306_FRAME_STROBE_EN
    logic       frame_done;
`endif

    always #5 clk_avr_16 = ~clk_avr_16;

    ssd1306_spi_sink dut (
        .clk_avr_16 (clk_avr_16),
        .reset_n    (reset_n),
        .oled_cs    (oled_cs),
        .oled_rst   (oled_rst),
        .oled_dc    (oled_dc),
        .oled_clk   (oled_clk),
        .oled_data  (oled_data),
        .fb_wr_en   (fb_wr_en),
        .fb_wr_addr (fb_wr_addr),
        .fb_wr_data (fb_wr_data),
        .display_on (display_on),
        .contrast   (contrast),
        .invert     (invert),
        .seg_remap  (seg_remap),
        .com_flip   (com_flip)
`ifdef SSD1306_FRAME_STROBE_EN
        ,
        .frame_done (frame_done)
`endif
    );

    typedef struct {
        int addr;
        int data;
        bit frame;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: pointer, window, mode, display controls, pending-argument bookkeeping.
    int m_col, m_page, m_cs, m_ce, m_ps, m_pe, m_mode, m_contrast;
    int m_on, m_inv, m_seg, m_com;
    int m_op, m_wait, m_argi;

    task automatic model_reset();
        m_col = 0; m_page = 0; m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7;
        m_mode = 2; m_contrast = 'h7F;
        m_on = 0; m_inv = 0; m_seg = 0; m_com = 0;
        m_op = 0; m_wait = 0; m_argi = 0;
    endtask

    task automatic model_byte(input bit dc, input int b);
        exp_t e;
        if (dc) begin
            e.addr = m_page * 128 + m_col;
            e.data = b;
            e.frame = 1'b0;
            if (m_mode == 0) begin
                m_col++;
                if (m_col > m_ce) begin
                    m_col = m_cs;
                    m_page++;
                    if (m_page > m_pe) begin m_page = m_ps; e.frame = 1'b1; end
                end
            end else if (m_mode == 1) begin
                m_page++;
                if (m_page > m_pe) begin
                    m_page = m_ps;
                    m_col++;
                    if (m_col > m_ce) begin m_col = m_cs; e.frame = 1'b1; end
                end
            end else begin
                m_col = (m_col == 127) ? 0 : m_col + 1;
            end
            exp_q.push_back(e);
        end else if (m_wait > 0) begin
            case (m_op)
                'h20: if ((b % 4) != 3) m_mode = b % 4;
                'h81: m_contrast = b;
                'h21: if (m_argi == 0) begin m_cs = b % 128; m_col = m_cs; end else m_ce = b % 128;
                'h22: if (m_argi == 0) begin m_ps = b % 8; m_page = m_ps; end else m_pe = b % 8;
                default: ;
            endcase
            m_argi++;
            m_wait--;
        end else begin
            m_op = b;
            m_argi = 0;
            case (b)
                'h20, 'h81, 'hA8, 'hD3, 'hD5, 'hD9, 'hDA, 'hDB, 'h8D: m_wait = 1;
                'h21, 'h22: m_wait = 2;
                'hAE: m_on = 0;
                'hAF: m_on = 1;
                'hA6: m_inv = 0;
                'hA7: m_inv = 1;
                'hA0: m_seg = 0;
                'hA1: m_seg = 1;
                'hC0: m_com = 0;
                'hC8: m_com = 1;
                default: begin
                    if (b < 16)                    m_col = (m_col / 16) * 16 + b;
                    else if (b < 32)               m_col = (m_col % 16) + (b % 8) * 16;
                    else if (b >= 'hB0 && b <= 'hB7) m_page = b % 8;
                end
            endcase
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_avr_16);
        #1;
    endtask

    task automatic send_bits(input int b, input int nbits, input bit dc);
        oled_dc = dc;
        for (int i = 7; i >= 8 - nbits; i--) begin
            oled_clk  = 1'b0;
            oled_data = b[i];
            tick(2);
            oled_clk = 1'b1;
            tick(2);
        end
        oled_clk = 1'b0;
    endtask

    task automatic send_byte(input bit dc, input int b);
        model_byte(dc, b);
        oled_cs = 1'b0;
        send_bits(b, 8, dc);
    endtask

    task automatic cmd(input int b);
        send_byte(1'b0, b);
    endtask

    task automatic dat(input int b);
        send_byte(1'b1, b);
    endtask

    task automatic end_cs();
        oled_cs = 1'b1;
        tick(6);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".display_on"}, int'(display_on), m_on);
        check({tag, ".contrast"},   int'(contrast),   m_contrast);
        check({tag, ".invert"},     int'(invert),     m_inv);
        check({tag, ".seg_remap"},  int'(seg_remap),  m_seg);
        check({tag, ".com_flip"},   int'(com_flip),   m_com);
    endtask

    // Monitor: every write strobe is matched against the oldest expected write.
    always @(negedge clk_avr_16) begin
        if (fb_wr_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr %0d data 0x%0h with nothing expected", fb_wr_addr, fb_wr_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (int'(fb_wr_addr) != e.addr || int'(fb_wr_data) != e.data) begin
                    errors++;
                    $display("FAIL fb_write: got addr %0d data 0x%0h expected addr %0d data 0x%0h",
                             fb_wr_addr, fb_wr_data, e.addr, e.data);
                end
`ifdef SSD1306_FRAME_STROBE_EN
                if (frame_done != e.frame) begin
                    errors++;
                    $display("FAIL frame_done: got %0d expected %0d at addr %0d", frame_done, e.frame, e.addr);
                end
`endif
            end
        end
`ifdef SSD1306_FRAME_STROBE_EN
        else if (frame_done) begin
            checks++;
            errors++;
            $display("FAIL frame_done_alone: got 1 expected 0 without fb_wr_en");
        end
`endif
    end

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 64) begin
            tick(1);
            n++;
        end
        check({tag, ".pending_writes"}, exp_q.size(), 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ops[19];
        ops = '{'h20, 'h21, 'h22, 'h81, 'hAE, 'hAF, 'hA6, 'hA7, 'hA0, 'hA1,
                'hC0, 'hC8, 'hA8, 'hD3, 'h8D, 'hB5, 'h03, 'h14, 'hE3};

        reset_n = 1'b0; oled_cs = 1'b1; oled_rst = 1'b1;
        oled_dc = 1'b0; oled_clk = 1'b0; oled_data = 1'b0;
        model_reset();
        tick(3);
        reset_n = 1'b1;
        tick(2);
        check_regs("reset");
        check("reset.fb_wr_en",   int'(fb_wr_en),   0);
        check("reset.fb_wr_addr", int'(fb_wr_addr), 0);

        // Display controls; no writes may appear.
        cmd('hAF); cmd('h81); cmd('h40);
        end_cs();
        check_regs("ctrl");
        check("ctrl.contrast_value", int'(contrast), 'h40);

        // Full-screen horizontal ramp, then one byte past the end.
        cmd('h20); cmd('h00); cmd('h21); cmd(0); cmd(127); cmd('h22); cmd(0); cmd(7);
        for (int i = 0; i < 1025; i++) dat(i % 256);
        end_cs();
        drain("ramp");

        // Page addressing with nibble column commands.
        cmd('h20); cmd('h02); cmd('hB3); cmd('h05); cmd('h11);
        dat('hAA); dat('h55);
        end_cs();
        drain("page");

        // Vertical addressing in a 2x2 window.
        cmd('h20); cmd('h01); cmd('h21); cmd(10); cmd(11); cmd('h22); cmd(6); cmd(7);
        for (int i = 0; i < 5; i++) dat(int'($urandom_range(0, 255)));
        end_cs();
        drain("vert");

        // Partial byte aborted by chip select, then a clean byte.
        oled_cs = 1'b0;
        send_bits(int'($urandom_range(0, 255)), 5, 1'b1);
        end_cs();
        dat('h3C);
        end_cs();
        drain("partial");

        // Controller reset in the middle of a column-address command.
        cmd('hAE); cmd('hA7); cmd('hA1); cmd('hC8); cmd('h81); cmd('h12);
        tick(4);
        check_regs("pre_rst");
        cmd('h21); cmd(5);
        tick(4);
        oled_rst = 1'b0;
        tick(2);
        oled_rst = 1'b1;
        model_reset();
        tick(2);
        check_regs("rst");
        dat(int'($urandom_range(0, 255)));
        end_cs();
        drain("rst");

        // Random mix of commands, arguments and data, with occasional chip-select drops.
        for (int i = 0; i < 300; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 5)      dat(int'($urandom_range(0, 255)));
            else if (r < 8) cmd(ops[$urandom_range(0, 18)]);
            else            cmd(int'($urandom_range(0, 255)));
            if ($urandom_range(0, 19) == 0) end_cs();
        end
        end_cs();
        drain("random");
        check_regs("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
